hive_alu_mul_shl_par: RTL
=========================

HIVE_ALU_MUL_SHL_PAR -- requirements
Module: hive_alu_mul_shl_par

Interface
REQ-001 SHALL have parameter ALU_W, default 32, data width (power of 2, 8..64).
REQ-002 SHALL have parameter PIPE, default 5, input-to-result latency in cycles (3..8).
REQ-003 SHALL have port clk_i  in  1  clock; one clock, all state on its rising edge.
REQ-004 SHALL have port rst_i  in  1  reset, asynchronous, active-high.
REQ-005 SHALL have port vld_i  in  1  operation valid.
REQ-006 SHALL have port flush_i  in  1  kill all in-flight operations.
REQ-007 SHALL have port op_i  in  MS_OP_W  operation code (MS_OP_T).
REQ-008 SHALL have port ext_i  in  1  multiply: return high word.
REQ-009 SHALL have port a_i  in  ALU_W  operand A.
REQ-010 SHALL have port b_i  in  ALU_W  operand B / signed shift amount.
REQ-011 SHALL have port result_o  out  ALU_W  result, unregistered, at stage PIPE.
REQ-012 SHALL have port vld_o  out  1  result_o valid.
REQ-013 SHALL have port flg_o  out  4  flags, registered, one cycle after result_o.

Function
REQ-014 SHALL support ops: mul_u, mul_us, mul_su, mul_s, shl_u, shl_s, rol, pow, shl_sat.
REQ-015 mul_*: SHALL form the 2*ALU_W+1-bit product with per-operand zero/sign extension; result is the low word, or the high word when ext_i=1.
REQ-016 Shift amount s = signed b_i; SEL_W = log2(ALU_W); in range means -ALU_W <= s <= ALU_W-1.
REQ-017 shl_u/shl_s, s >= 0: SHALL return A<<s (low word); s < 0: SHALL return A>>|s| (logical for shl_u, arithmetic for shl_s), taken from the high word of A*2^(s mod ALU_W).
REQ-018 shl out of range: SHALL return 0, except shl_s with s < -ALU_W and A negative, which SHALL return all ones (sign fill).
REQ-019 rol: SHALL return A rotated left by s mod ALU_W (high word OR low word); range is ignored.
REQ-020 pow: SHALL return 1<<s for 0 <= s <= ALU_W-1, and 0 otherwise.
REQ-021 shl_sat: SHALL perform signed A<<s for 0 <= s <= ALU_W-1.
REQ-022 shl_sat: when product bits [2*ALU_W-1:ALU_W-1] are not all equal, SHALL clamp to 0x7F..F (A >= 0) or 0x80..0 (A < 0).
REQ-023 shl_sat: s < 0 SHALL behave as shl_s.
REQ-024 SHALL be fully pipelined: one op accepted every cycle, no stall.
REQ-025 vld_o SHALL equal vld_i delayed PIPE cycles.
REQ-026 Every per-op control bit SHALL travel in a shift register aligned to the multiplier latency.
REQ-027 flush_i SHALL clear every in-flight valid bit at the same edge, including an op presented in that cycle.
REQ-028 flush_i SHALL NOT clear an op presented the following cycle; result_o is don't-care while vld_o=0.
REQ-029 flg_o[3:0] SHALL equal {prod[2W], |prod[2W-1:W], &prod[2W-1:W], prod[W-1]}, registered.
REQ-030 flg_o SHALL update only when the stage-PIPE valid bit is 1, and hold otherwise.
REQ-031 An undefined op_i with vld_i=1 SHALL drive 'x controls in simulation; with vld_i=0 the op is ignored.

Reset
REQ-032 rst_i SHALL asynchronously clear all pipeline registers, vld_o and flg_o to 0.
REQ-033 rst_i asserted mid-operation SHALL discard all in-flight ops; there SHALL be no vld_o for them after release.

Configuration
REQ-034 With HIVE_ALU_SAT_EN defined, shl_sat and its clamp logic SHALL be built.
REQ-035 Without HIVE_ALU_SAT_EN, shl_sat SHALL decode as shl_s, with no clamp hardware.

Structure
REQ-036 MS_OP_T, MS_OP_W and the op encodings SHALL live in package hive_types.
REQ-037 Derived constants (SEL_W, DBL_W, MUL_W) SHALL be localparams computed from ALU_W.
REQ-038 SHALL instantiate sub-module hive_alu_multiply, parametrised by width (ALU_W+1 signed) and latency PIPE-1.

Verification (ALU_W=32, PIPE=5)
REQ-039 mul_s a=0xFFFFFFFD b=7: ext=0 -> 0xFFFFFFEB; ext=1 -> 0xFFFFFFFF; vld_o exactly 5 cycles after vld_i.
REQ-040 a=0x80000001: shl_u b=1 -> 0x00000002; shl_u b=-1 -> 0x40000000; shl_s b=-1 -> 0xC0000000; shl_s b=40 -> 0; shl_s a=0x80000000 b=-40 -> 0xFFFFFFFF.
REQ-041 rol a=0x80000001 b=4 -> 0x00000018; pow b=31 -> 0x80000000; pow b=32 -> 0.
REQ-042 shl_sat a=0x40000000 b=1 -> 0x7FFFFFFF; a=0xC0000000 b=2 -> 0x80000000; a=0x00000003 b=4 -> 0x00000030; without the macro, a=0x40000000 b=1 -> 0x80000000.
REQ-043 Back-to-back: 8 valid ops on consecutive cycles, flush_i pulsed with op 4 -> vld_o only for ops 5..8, with correct results.
REQ-044 Reset: rst_i pulsed with 3 ops in flight -> vld_o=0 and flg_o=0 immediately and for the following 5 cycles.

Source files
------------

// File: rtl/hive_alu_mul_shl_par_pkg.sv
// hive_types: shared types for the hive multiply/shift ALU slice.
//   MS_OP_W / MS_OP_T : operation code width and encodings.
//     mul_<a><b> : u = operand zero-extended, s = operand sign-extended
//                  (mul_us = A unsigned x B signed, mul_su = A signed x B unsigned).
//   ms_ctrl_t        : per-op control bits carried alongside the multiplier.
// Optional feature macro: HIVE_ALU_SAT_EN (adds the saturation control fields).
package hive_types;

  localparam int unsigned MS_OP_W = 4;

  typedef enum logic [MS_OP_W-1:0] {
    OP_MUL_U   = 4'd0,
    OP_MUL_US  = 4'd1,
    OP_MUL_SU  = 4'd2,
    OP_MUL_S   = 4'd3,
    OP_SHL_U   = 4'd4,
    OP_SHL_S   = 4'd5,
    OP_ROL     = 4'd6,
    OP_POW     = 4'd7,
    OP_SHL_SAT = 4'd8
  } MS_OP_T;

  typedef struct packed {
    logic sel_hi;   // return high word instead of low word
    logic sel_or;   // return high | low (rotate)
    logic frc;      // override result with fill value
    logic fill;     // override value: 1 = all ones, 0 = zero
`ifdef HIVE_ALU_SAT_EN
    logic sat_chk;  // apply signed saturation check
    logic a_neg;    // sign of A, selects clamp value
`endif
  } ms_ctrl_t;

endpackage

// File: rtl/hive_alu_mul_shl_par_multiply.sv
// hive_alu_multiply: pipelined signed multiplier.
//   clk_i, rst_i : clock, asynchronous active-high reset
//   a_i, b_i     : W-bit signed operands
//   p_o          : low OUT_W bits of the signed product, LAT cycles later
module hive_alu_multiply #(
  parameter int unsigned W     = 33,
  parameter int unsigned LAT   = 4,
  parameter int unsigned OUT_W = 2*W
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic signed [W-1:0]  a_i,
  input  logic signed [W-1:0]  b_i,
  output logic [OUT_W-1:0]     p_o
);

  logic signed [OUT_W-1:0]      w_p;
  logic [LAT-1:0][OUT_W-1:0]    r_p;

  assign w_p = OUT_W'(a_i) * OUT_W'(b_i);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) r_p <= '0;
    else       r_p <= {r_p[LAT-2:0], w_p};
  end

  assign p_o = r_p[LAT-1];

endmodule

// File: rtl/hive_alu_mul_shl_par.sv
// hive_alu_mul_shl_par: pipelined multiply / shift / rotate / power-of-2 ALU.
// All shifts are done on the multiplier by multiplying A with 2^(s mod ALU_W).
//   clk_i, rst_i : clock, asynchronous active-high reset
//   vld_i        : operation valid        flush_i : kill all in-flight ops
//   op_i         : MS_OP_T opcode         ext_i   : multiply returns high word
//   a_i, b_i     : operands (b_i = signed shift amount for shifts)
//   result_o     : result at stage PIPE (combinational), valid with vld_o
//   flg_o        : {prod[2W], |hi, &hi, prod[W-1]}, registered, one cycle later
// Optional feature macro: HIVE_ALU_SAT_EN builds shl_sat with clamp logic;
// without it shl_sat decodes as shl_s.
module hive_alu_mul_shl_par
  import hive_types::*;
#(
  parameter int unsigned ALU_W = 32,
  parameter int unsigned PIPE  = 5
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               vld_i,
  input  logic               flush_i,
  input  logic [MS_OP_W-1:0] op_i,
  input  logic               ext_i,
  input  logic [ALU_W-1:0]   a_i,
  input  logic [ALU_W-1:0]   b_i,
  output logic [ALU_W-1:0]   result_o,
  output logic               vld_o,
  output logic [3:0]         flg_o
);

  localparam int unsigned SEL_W = $clog2(ALU_W);
  localparam int unsigned DBL_W = 2*ALU_W;
  localparam int unsigned MUL_W = ALU_W + 1;

  logic [SEL_W-1:0]        w_sh;
  logic                    w_s_neg;
  logic                    w_in_rng;
  logic [ALU_W-1:0]        w_pow2;
  logic signed [MUL_W-1:0] w_ma, w_mb;
  ms_ctrl_t                w_ctrl;

  logic signed [MUL_W-1:0] r_ma, r_mb;
  logic [PIPE-1:0]         r_vld;
  ms_ctrl_t [PIPE-1:0]     r_ctrl;
  logic [3:0]              r_flg;

  logic [DBL_W:0]          w_p;
  logic [ALU_W-1:0]        w_lo, w_hi, w_res;
  ms_ctrl_t                w_c;

  // s in [-ALU_W, ALU_W-1] exactly when floor(s/ALU_W) is 0 or -1
  assign w_sh     = b_i[SEL_W-1:0];
  assign w_s_neg  = b_i[ALU_W-1];
  assign w_in_rng = (&b_i[ALU_W-1:SEL_W]) | ~(|b_i[ALU_W-1:SEL_W]);
  assign w_pow2   = {{(ALU_W-1){1'b0}}, 1'b1} << w_sh;

  always_comb begin
    w_ma   = '0;
    w_mb   = '0;
    w_ctrl = '0;
    case (op_i)
      OP_MUL_U:  begin w_ma = {1'b0, a_i};         w_mb = {1'b0, b_i};         w_ctrl.sel_hi = ext_i; end
      OP_MUL_US: begin w_ma = {1'b0, a_i};         w_mb = {b_i[ALU_W-1], b_i}; w_ctrl.sel_hi = ext_i; end
      OP_MUL_SU: begin w_ma = {a_i[ALU_W-1], a_i}; w_mb = {1'b0, b_i};         w_ctrl.sel_hi = ext_i; end
      OP_MUL_S:  begin w_ma = {a_i[ALU_W-1], a_i}; w_mb = {b_i[ALU_W-1], b_i}; w_ctrl.sel_hi = ext_i; end
      OP_SHL_U: begin
        w_ma = {1'b0, a_i};
        w_mb = {1'b0, w_pow2};
        w_ctrl.sel_hi = w_s_neg;
        w_ctrl.frc    = ~w_in_rng;
      end
`ifdef HIVE_ALU_SAT_EN
      OP_SHL_S: begin
        w_ma = {a_i[ALU_W-1], a_i};
        w_mb = {1'b0, w_pow2};
        w_ctrl.sel_hi = w_s_neg;
        w_ctrl.frc    = ~w_in_rng;
        w_ctrl.fill   = w_s_neg & a_i[ALU_W-1];
      end
      OP_SHL_SAT: begin
        w_ma = {a_i[ALU_W-1], a_i};
        w_mb = {1'b0, w_pow2};
        w_ctrl.sel_hi  = w_s_neg;
        w_ctrl.frc     = ~w_in_rng;
        w_ctrl.fill    = w_s_neg & a_i[ALU_W-1];
        w_ctrl.sat_chk = ~w_s_neg & w_in_rng;
        w_ctrl.a_neg   = a_i[ALU_W-1];
      end
`else
      OP_SHL_S, OP_SHL_SAT: begin
        w_ma = {a_i[ALU_W-1], a_i};
        w_mb = {1'b0, w_pow2};
        w_ctrl.sel_hi = w_s_neg;
        w_ctrl.frc    = ~w_in_rng;
        w_ctrl.fill   = w_s_neg & a_i[ALU_W-1];
      end
`endif
      OP_ROL: begin
        w_ma = {1'b0, a_i};
        w_mb = {1'b0, w_pow2};
        w_ctrl.sel_or = 1'b1;
      end
      OP_POW: begin
        w_ma = {{(MUL_W-1){1'b0}}, 1'b1};
        w_mb = {1'b0, w_pow2};
        w_ctrl.frc = w_s_neg | ~w_in_rng;
      end
      default: begin
        if (vld_i) begin
          w_ma   = 'x;
          w_mb   = 'x;
          w_ctrl = 'x;
        end
      end
    endcase
  end

  // operand register is stage 1; the multiplier supplies the other PIPE-1 stages
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_ma   <= '0;
      r_mb   <= '0;
      r_vld  <= '0;
      r_ctrl <= '0;
    end else begin
      r_ma   <= w_ma;
      r_mb   <= w_mb;
      r_vld  <= flush_i ? '0 : {r_vld[PIPE-2:0], vld_i};
      r_ctrl <= {r_ctrl[PIPE-2:0], w_ctrl};
    end
  end

  hive_alu_multiply #(
    .W    (MUL_W),
    .LAT  (PIPE-1),
    .OUT_W(DBL_W+1)
  ) u_mul (
    .clk_i(clk_i),
    .rst_i(rst_i),
    .a_i  (r_ma),
    .b_i  (r_mb),
    .p_o  (w_p)
  );

  assign w_lo = w_p[ALU_W-1:0];
  assign w_hi = w_p[DBL_W-1:ALU_W];
  assign w_c  = r_ctrl[PIPE-1];

`ifdef HIVE_ALU_SAT_EN
  logic [ALU_W:0] w_band;
  assign w_band = w_p[DBL_W-1:ALU_W-1];
`endif

  always_comb begin
    if (w_c.frc)         w_res = w_c.fill ? '1 : '0;
    else if (w_c.sel_or) w_res = w_hi | w_lo;
    else if (w_c.sel_hi) w_res = w_hi;
    else                 w_res = w_lo;
`ifdef HIVE_ALU_SAT_EN
    if (w_c.sat_chk && !((&w_band) || !(|w_band)))
      w_res = w_c.a_neg ? {1'b1, {(ALU_W-1){1'b0}}} : {1'b0, {(ALU_W-1){1'b1}}};
`endif
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i)              r_flg <= '0;
    else if (r_vld[PIPE-1]) r_flg <= {w_p[DBL_W], |w_hi, &w_hi, w_lo[ALU_W-1]};
  end

  assign result_o = w_res;
  assign vld_o    = r_vld[PIPE-1];
  assign flg_o    = r_flg;

endmodule
